// File: rtl/render_sram_arbiter_if.sv
// rtl/render_sram_arbiter_if.sv - render/write/SRAM bus bundle for render_sram_arbiter
//
// Purpose: groups every non-clock, non-reset signal of render_sram_arbiter.
// Ports (names keep the i_/o_ direction seen from the arbiter):
//   i_render_en, i_render_h, i_render_v : pixel being rendered by the VGA timing
//   o_color                             : RGB888 colour back to the VGA
//   i_wr_valid, o_wr_ready, i_wr_addr,
//   i_wr_data                           : single-word write request handshake
//   o_sram_addr, o_sram_wdata,
//   o_sram_we_n, o_sram_oe_n,
//   i_sram_rdata                        : asynchronous SRAM pins
//   o_wr_stall                          : cycles the buffered write has waited
// Modports: master = driver of the arbiter inputs, slave = the arbiter.
interface render_sram_arbiter_if #(
  parameter int H_WIDTH = 11,
  parameter int V_WIDTH = 10
);
  logic               i_render_en;
  logic [H_WIDTH-1:0] i_render_h;
  logic [V_WIDTH-1:0] i_render_v;
  logic [23:0]        o_color;
  logic               i_wr_valid;
  logic               o_wr_ready;
  logic [19:0]        i_wr_addr;
  logic [15:0]        i_wr_data;
  logic [19:0]        o_sram_addr;
  logic [15:0]        o_sram_wdata;
  logic               o_sram_we_n;
  logic               o_sram_oe_n;
  logic [15:0]        i_sram_rdata;
  logic [15:0]        o_wr_stall;

  modport master (
    output i_render_en, i_render_h, i_render_v,
    output i_wr_valid, i_wr_addr, i_wr_data, i_sram_rdata,
    input  o_color, o_wr_ready, o_sram_addr, o_sram_wdata,
    input  o_sram_we_n, o_sram_oe_n, o_wr_stall
  );

  modport slave (
    input  i_render_en, i_render_h, i_render_v,
    input  i_wr_valid, i_wr_addr, i_wr_data, i_sram_rdata,
    output o_color, o_wr_ready, o_sram_addr, o_sram_wdata,
    output o_sram_we_n, o_sram_oe_n, o_wr_stall
  );
endinterface

// File: rtl/render_sram_arbiter.sv
// rtl/render_sram_arbiter.sv - single-port SRAM arbiter between VGA render reads and buffered writes
//
// Purpose: each rendered map cell is fetched from SRAM once (first screen pixel
// of the cell), expanded RGB565 -> RGB888 and held for the remaining pixels.
// Any cycle that is not a fetch may drain a one-entry write buffer.
// Ports:
//   i_clk : clock, all logic on the rising edge
//   i_rst : asynchronous active-high reset
//   bus   : render_sram_arbiter_if.slave (render pixel in, colour out, write
//           request handshake, SRAM pins, write stall counter)
package sram_pkg;
  localparam int MAP_H_WIDTH = 11;
  localparam int MAP_V_WIDTH = 10;
endpackage

module render_sram_arbiter #(
  parameter int H_SIZE = 1600,
  parameter int V_SIZE = 900,
  parameter int SHIFT  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  render_sram_arbiter_if.slave  bus
);

  localparam logic [19:0] LINE_WORDS = 20'(H_SIZE >> SHIFT);
  localparam logic [19:0] SUB_MASK   = 20'((1 << SHIFT) - 1);

  typedef enum logic {EMPTY, FULL} wr_state_t;

  logic [sram_pkg::MAP_H_WIDTH-1:0] h;
  logic [sram_pkg::MAP_V_WIDTH-1:0] v;
  assign h = bus.i_render_h;
  assign v = bus.i_render_v;

  wr_state_t   state;
  logic [19:0] buf_addr;
  logic [15:0] buf_data;
  logic [15:0] hold_q;
  logic [23:0] color_q;
  logic [19:0] sram_addr_q;
  logic [15:0] sram_wdata_q;
  logic        sram_we_n_q;
  logic        sram_oe_n_q;
  logic        wr_ready_q;
  logic [15:0] wr_stall_q;

  logic [19:0] h_idx;
  logic [19:0] v_idx;
  logic [19:0] rd_addr;
  logic        h_in_line;
  logic        read_slot;
  logic        accept;
  logic [15:0] hold_d;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // Screen coordinates are 1-based; h=0 marks blanking. The multiply wraps at
  // 20 bits, which is the required address truncation.
  always_comb begin
    h_idx     = 20'(h) - 20'd1;
    v_idx     = 20'(v) - 20'd1;
    rd_addr   = (v_idx >> SHIFT) * LINE_WORDS + (h_idx >> SHIFT);
    h_in_line = (h != '0) && (32'(h) <= 32'(H_SIZE));
    read_slot = bus.i_render_en && h_in_line && ((h_idx & SUB_MASK) == 20'd0);
    accept    = bus.i_wr_valid && wr_ready_q;
    // The SRAM answers in the same cycle the read address is on the pins,
    // i.e. the cycle after the read slot; only then is rdata meaningful.
    hold_d    = !sram_oe_n_q ? bus.i_sram_rdata : hold_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= EMPTY;
      buf_addr     <= '0;
      buf_data     <= '0;
      hold_q       <= '0;
      color_q      <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_we_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      wr_ready_q   <= 1'b1;
      wr_stall_q   <= '0;
    end else begin
      hold_q  <= hold_d;
      color_q <= rgb565_to_888(hold_d);

      // Reads win every slot; a buffered write only uses a non-read slot.
      if (read_slot) begin
        sram_addr_q <= rd_addr;
        sram_oe_n_q <= 1'b0;
        sram_we_n_q <= 1'b1;
      end else if (state == FULL) begin
        sram_addr_q  <= buf_addr;
        sram_wdata_q <= buf_data;
        sram_we_n_q  <= 1'b0;
        sram_oe_n_q  <= 1'b1;
      end else begin
        sram_we_n_q <= 1'b1;
        sram_oe_n_q <= 1'b1;
      end

      case (state)
        EMPTY: begin
          if (accept) begin
            buf_addr <= bus.i_wr_addr;
            buf_data <= bus.i_wr_data;
            state    <= FULL;
          end
        end
        FULL: begin
          if (!read_slot) begin
            state      <= EMPTY;
            wr_stall_q <= '0;
          end else if (wr_stall_q != 16'hFFFF) begin
            wr_stall_q <= wr_stall_q + 16'd1;
          end
        end
        default: state <= EMPTY;
      endcase

      // Ready follows the registered state, so it reopens the cycle after the
      // strobe and drops immediately on accept.
      wr_ready_q <= (state == EMPTY) && !accept;
    end
  end

  // Rendered lines never exceed the frame height.
  always @(posedge i_clk) begin
    if (!i_rst && read_slot) begin
      assert ((v != '0) && (32'(v) <= 32'(V_SIZE)));
    end
  end

  assign bus.o_color      = color_q;
  assign bus.o_sram_addr  = sram_addr_q;
  assign bus.o_sram_wdata = sram_wdata_q;
  assign bus.o_sram_we_n  = sram_we_n_q;
  assign bus.o_sram_oe_n  = sram_oe_n_q;
  assign bus.o_wr_ready   = wr_ready_q;
  assign bus.o_wr_stall   = wr_stall_q;

endmodule

// File: tb/tb_render_sram_arbiter.sv
// tb/tb_render_sram_arbiter.sv - directed self-checking bench for render_sram_arbiter
module tb_render_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  render_sram_arbiter_if bus ();
  render_sram_arbiter_if bus0 ();

  render_sram_arbiter #(.H_SIZE(1600), .V_SIZE(900), .SHIFT(1)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave)
  );
  render_sram_arbiter #(.H_SIZE(1600), .V_SIZE(900), .SHIFT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0.slave)
  );

  int ncmp = 0;
  int nfail = 0;

  typedef struct {
    logic        en;
    logic [10:0] h;
    logic [9:0]  v;
    logic [15:0] rdata;
    logic        rd;
    logic [19:0] exp_addr;
    logic [23:0] exp_color;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] rgb(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic logic [15:0] rd_pat(input int k);
    return 16'(32'h1000 + k * 32'h123);
  endfunction

  initial begin
    logic [23:0] exp_color;
    logic        strobe_seen;

    vecs[0] = '{1'b1, 11'd1,    10'd1,   16'hF800, 1'b1, 20'd0,      24'hFF0000};
    vecs[1] = '{1'b1, 11'd5,    10'd3,   16'h07E0, 1'b1, 20'd802,    24'h00FF00};
    vecs[2] = '{1'b1, 11'd1599, 10'd900, 16'h001F, 1'b1, 20'd359999, 24'h0000FF};
    vecs[3] = '{1'b1, 11'd3,    10'd2,   16'hFFFF, 1'b1, 20'd1,      24'hFFFFFF};
    vecs[4] = '{1'b1, 11'd801,  10'd11,  16'h8410, 1'b1, 20'd4400,   24'h848284};
    vecs[5] = '{1'b1, 11'd257,  10'd5,   16'h1234, 1'b1, 20'd1728,   24'h1045A5};
    vecs[6] = '{1'b1, 11'd0,    10'd1,   16'hF800, 1'b0, 20'd1728,   24'h1045A5};
    vecs[7] = '{1'b1, 11'd1601, 10'd1,   16'hF800, 1'b0, 20'd1728,   24'h1045A5};
    vecs[8] = '{1'b1, 11'd2,    10'd1,   16'hF800, 1'b0, 20'd1728,   24'h1045A5};
    vecs[9] = '{1'b0, 11'd1,    10'd1,   16'hF800, 1'b0, 20'd1728,   24'h1045A5};

    rst = 1'b1;
    bus.i_render_en = 0;  bus.i_render_h = 0;  bus.i_render_v = 0;
    bus.i_wr_valid = 0;   bus.i_wr_addr = 0;   bus.i_wr_data = 0;  bus.i_sram_rdata = 0;
    bus0.i_render_en = 0; bus0.i_render_h = 0; bus0.i_render_v = 0;
    bus0.i_wr_valid = 0;  bus0.i_wr_addr = 0;  bus0.i_wr_data = 0; bus0.i_sram_rdata = 0;
    repeat (3) cyc();

    check("rst_color", bus.o_color, 24'h0);
    check("rst_addr", bus.o_sram_addr, 20'h0);
    check("rst_wdata", bus.o_sram_wdata, 16'h0);
    check("rst_we_n", bus.o_sram_we_n, 1'b1);
    check("rst_oe_n", bus.o_sram_oe_n, 1'b1);
    check("rst_ready", bus.o_wr_ready, 1'b1);
    check("rst_stall", bus.o_wr_stall, 16'h0);
    rst = 1'b0;
    cyc();

    // Table: one slot per vector, address/strobes at +1, colour at +2.
    for (int i = 0; i < 10; i++) begin
      bus.i_render_en = vecs[i].en;
      bus.i_render_h  = vecs[i].h;
      bus.i_render_v  = vecs[i].v;
      bus.i_sram_rdata = 16'h0;
      cyc();
      check($sformatf("vec%0d_addr", i), bus.o_sram_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_oe_n", i), bus.o_sram_oe_n, !vecs[i].rd);
      check($sformatf("vec%0d_we_n", i), bus.o_sram_we_n, 1'b1);
      bus.i_render_en = 1'b0;
      bus.i_sram_rdata = vecs[i].rdata;
      cyc();
      check($sformatf("vec%0d_color", i), bus.o_color, vecs[i].exp_color);
      bus.i_sram_rdata = 16'h0;
    end

    // Consecutive pixels h=1..4 on line 1: reads at h=1 and h=3 only.
    bus.i_render_en = 1; bus.i_render_v = 1; bus.i_render_h = 1;
    cyc();
    check("seq_h1_addr", bus.o_sram_addr, 20'd0);
    check("seq_h1_oe_n", bus.o_sram_oe_n, 1'b0);
    check("seq_h1_color_not_yet", bus.o_color, 24'h1045A5);
    bus.i_render_h = 2; bus.i_sram_rdata = 16'hF800;
    cyc();
    check("seq_h2_oe_n", bus.o_sram_oe_n, 1'b1);
    check("seq_h2_addr_held", bus.o_sram_addr, 20'd0);
    check("seq_h1_color", bus.o_color, 24'hFF0000);
    bus.i_render_h = 3; bus.i_sram_rdata = 16'h0000;
    cyc();
    check("seq_h3_addr", bus.o_sram_addr, 20'd1);
    check("seq_h3_oe_n", bus.o_sram_oe_n, 1'b0);
    check("seq_free_keeps_hold", bus.o_color, 24'hFF0000);
    bus.i_render_h = 4; bus.i_sram_rdata = 16'h07E0;
    cyc();
    check("seq_h4_oe_n", bus.o_sram_oe_n, 1'b1);
    check("seq_h3_color", bus.o_color, 24'h00FF00);
    bus.i_render_en = 0; bus.i_sram_rdata = 16'h0;
    cyc();

    // Write while not rendering: strobe two cycles after accept.
    check("wr_ready_before", bus.o_wr_ready, 1'b1);
    bus.i_wr_valid = 1; bus.i_wr_addr = 20'h12345; bus.i_wr_data = 16'hABCD;
    cyc();
    bus.i_wr_valid = 0; bus.i_wr_addr = 20'h0; bus.i_wr_data = 16'h0;
    check("wr_t1_ready", bus.o_wr_ready, 1'b0);
    check("wr_t1_no_early_strobe", bus.o_sram_we_n, 1'b1);
    cyc();
    check("wr_t2_we_n", bus.o_sram_we_n, 1'b0);
    check("wr_t2_oe_n", bus.o_sram_oe_n, 1'b1);
    check("wr_t2_addr", bus.o_sram_addr, 20'h12345);
    check("wr_t2_wdata", bus.o_sram_wdata, 16'hABCD);
    cyc();
    check("wr_t3_ready", bus.o_wr_ready, 1'b1);
    check("wr_t3_we_n", bus.o_sram_we_n, 1'b1);
    check("wr_t3_addr_held", bus.o_sram_addr, 20'h12345);
    check("wr_t3_wdata_held", bus.o_sram_wdata, 16'hABCD);
    check("wr_t3_stall", bus.o_wr_stall, 16'h0);

    // Write during an active line: drains in the first even-h slot.
    exp_color = 24'h00FF00;
    for (int k = 0; k < 10; k++) begin
      if (k >= 1) begin
        if ((k - 1) <= 7 && ((k - 1) % 2) == 0) begin
          check($sformatf("line_k%0d_oe_n", k), bus.o_sram_oe_n, 1'b0);
          check($sformatf("line_k%0d_we_n", k), bus.o_sram_we_n, 1'b1);
          check($sformatf("line_k%0d_addr", k), bus.o_sram_addr, 20'((k - 1) >> 1));
        end else if (k - 1 == 3) begin
          check("line_drain_we_n", bus.o_sram_we_n, 1'b0);
          check("line_drain_oe_n", bus.o_sram_oe_n, 1'b1);
          check("line_drain_addr", bus.o_sram_addr, 20'hABCDE);
          check("line_drain_wdata", bus.o_sram_wdata, 16'h5A5A);
        end else begin
          check($sformatf("line_k%0d_idle_we_n", k), bus.o_sram_we_n, 1'b1);
          check($sformatf("line_k%0d_idle_oe_n", k), bus.o_sram_oe_n, 1'b1);
        end
      end
      if (k >= 2 && (k - 2) <= 7 && ((k - 2) % 2) == 0) exp_color = rgb(rd_pat(k - 1));
      check($sformatf("line_k%0d_color", k), bus.o_color, exp_color);
      if (k == 1) check("line_ready_k1", bus.o_wr_ready, 1'b1);
      if (k == 3) check("line_ready_k3", bus.o_wr_ready, 1'b0);
      if (k == 3) check("line_stall_k3", bus.o_wr_stall, 16'd1);
      if (k == 4) check("line_stall_k4", bus.o_wr_stall, 16'd0);
      if (k == 5) check("line_ready_k5", bus.o_wr_ready, 1'b1);
      bus.i_render_en  = (k <= 7);
      bus.i_render_h   = 11'(k + 1);
      bus.i_render_v   = 10'd1;
      bus.i_sram_rdata = rd_pat(k);
      bus.i_wr_valid   = (k == 1);
      bus.i_wr_addr    = 20'hABCDE;
      bus.i_wr_data    = 16'h5A5A;
      cyc();
    end
    bus.i_render_en = 0; bus.i_wr_valid = 0;

    // SHIFT=0 instance: every pixel reads, so the write starves.
    bus0.i_render_en = 1; bus0.i_render_h = 5; bus0.i_render_v = 1; bus0.i_sram_rdata = 16'hF800;
    cyc();
    check("starve_ready_before", bus0.o_wr_ready, 1'b1);
    bus0.i_wr_valid = 1; bus0.i_wr_addr = 20'h00F0F; bus0.i_wr_data = 16'h1357;
    strobe_seen = 1'b0;
    for (int i = 1; i <= 70000; i++) begin
      cyc();
      if (i == 1) begin
        bus0.i_wr_valid = 0;
        check("starve_ready_after", bus0.o_wr_ready, 1'b0);
      end
      if (bus0.o_sram_we_n == 1'b0) strobe_seen = 1'b1;
      if (i == 100) check("starve_stall_100", bus0.o_wr_stall, 16'd99);
    end
    check("starve_no_strobe", strobe_seen, 1'b0);
    check("starve_stall_sat", bus0.o_wr_stall, 16'hFFFF);
    check("starve_addr", bus0.o_sram_addr, 20'd4);
    check("starve_color", bus0.o_color, 24'hFF0000);

    // Asynchronous reset while the starved write is still buffered.
    #3 rst = 1'b1;
    #1;
    check("arst_color", bus0.o_color, 24'h0);
    check("arst_addr", bus0.o_sram_addr, 20'h0);
    check("arst_wdata", bus0.o_sram_wdata, 16'h0);
    check("arst_we_n", bus0.o_sram_we_n, 1'b1);
    check("arst_oe_n", bus0.o_sram_oe_n, 1'b1);
    check("arst_ready", bus0.o_wr_ready, 1'b1);
    check("arst_stall", bus0.o_wr_stall, 16'h0);
    check("arst_dut1_wdata", bus.o_sram_wdata, 16'h0);
    check("arst_dut1_color", bus.o_color, 24'h0);
    cyc();
    rst = 1'b0;
    bus0.i_render_en = 0;
    strobe_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus0.o_sram_we_n == 1'b0) strobe_seen = 1'b1;
    end
    check("post_rst_no_strobe", strobe_seen, 1'b0);
    check("post_rst_ready", bus0.o_wr_ready, 1'b1);
    check("post_rst_stall", bus0.o_wr_stall, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
